// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
//   XLEN          - datapath / PC width
//   INSTR_BYTES   - PC increment per fetched instruction word
//   fetch_entry_t - one buffered instruction with the PC it was fetched from
//   pc_align()    - forces a PC onto a word boundary
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding fetch_entry_t records.
//   clk, reset      - clock, asynchronous active-low reset
//   push, wr_entry  - write one entry (ignored when full unless popping too)
//   pop             - consume the head entry (ignored when empty)
//   flush           - drop all contents; overrides push and pop
//   rd_entry        - head entry, meaningful only when !empty
//   full, empty     - occupancy flags
//   count           - current occupancy, 0..FIFO_DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  fetch_entry_t                      wr_entry,
    input  logic                              pop,
    input  logic                              flush,
    output fetch_entry_t                      rd_entry,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH):0]       count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // a full buffer may still accept a write when the head leaves the same cycle
    assign do_push = push && (!full || do_pop) && !flush;

    assign rd_entry = mem[rd_ptr];

    // pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues word reads to instruction memory,
// buffers returned words with their PCs and presents them to decode.
//   clk, reset                      - clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     - taken branch; restart fetch at target
//   imem_req_valid/ready/addr       - read request channel
//   imem_resp_valid/data            - in-order read responses, no backpressure
//   inst_valid/ready/data/pc        - decode handoff channel
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int              CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credits_used;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    fetch_entry_t    head;

    // Every request in flight owns a buffer slot, so a response always finds room.
    assign credits_used   = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = reset && !redirect_valid
                            && (credits_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        outstanding_next = outstanding;
        if (req_fire)        outstanding_next = outstanding_next + CW'(1);
        if (imem_resp_valid) outstanding_next = outstanding_next - CW'(1);
    end

    assign push = imem_resp_valid && !redirect_valid && (drop_cnt == '0);
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid = !fifo_empty;
    // zeroed when empty so decode sees clean values during and right after reset
    assign inst_data  = fifo_empty ? '0 : head.data;
    assign inst_pc    = fifo_empty ? '0 : head.pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= pc_align(redirect_pc);
                resp_pc  <= pc_align(redirect_pc);
                // whatever is still in flight after this edge belongs to the old path
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + STEP;
                if (imem_resp_valid) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                    else                resp_pc  <= resp_pc + STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wr_entry ('{data: imem_resp_data, pc: resp_pc}),
        .pop      (pop),
        .flush    (redirect_valid),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    resp_needs_request: assert property (@(posedge clk) disable iff (!reset)
        imem_resp_valid |-> (outstanding != '0));

    resp_has_room: assert property (@(posedge clk) disable iff (!reset)
        push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    // second instance starting near the top of the address space
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_resp_valid;
    logic [31:0] w_resp_data;
    logic        w_inst_valid;
    logic        w_inst_ready;
    logic [31:0] w_inst_data;
    logic [31:0] w_inst_pc;

    int n_checks = 0;
    int n_pass   = 0;
    int mem_lat  = 1;
    int cyc      = 0;

    logic [31:0] pc_log[$];
    logic [31:0] data_log[$];
    logic [31:0] req_log[$];
    logic [31:0] w_req_log[$];
    logic [31:0] w_pc_log[$];
    logic [31:0] w_data_log[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    logic        hs;
    logic [31:0] hs_addr;
    logic        w_hs;
    logic [31:0] w_hs_addr;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_wrap (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (w_redirect_valid),
        .redirect_pc     (w_redirect_pc),
        .imem_req_valid  (w_req_valid),
        .imem_req_ready  (w_req_ready),
        .imem_req_addr   (w_req_addr),
        .imem_resp_valid (w_resp_valid),
        .imem_resp_data  (w_resp_data),
        .inst_valid      (w_inst_valid),
        .inst_ready      (w_inst_ready),
        .inst_data       (w_inst_data),
        .inst_pc         (w_inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_F00D;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_DEAD;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    // memory models: handshake seen at the negedge is accepted at the next posedge
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        w_resp_valid    = 1'b0;
        w_resp_data     = '0;
        forever begin
            @(negedge clk);
            hs        = imem_req_valid && imem_req_ready;
            hs_addr   = imem_req_addr;
            w_hs      = w_req_valid && w_req_ready;
            w_hs_addr = w_req_addr;
            @(posedge clk);
            #1;
            cyc++;
            if (!reset) begin
                pend.delete();
                imem_resp_valid = 1'b0;
                w_resp_valid    = 1'b0;
            end else begin
                if (hs) pend.push_back('{addr: hs_addr, due: cyc + mem_lat - 1});
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(pend[0].addr);
                    void'(pend.pop_front());
                end else begin
                    imem_resp_valid = 1'b0;
                    imem_resp_data  = '0;
                end
                w_resp_valid = w_hs;
                w_resp_data  = mem_word(w_hs_addr);
            end
        end
    end

    // decode-side and request-side monitors
    always @(negedge clk) begin
        if (reset) begin
            if (inst_valid && inst_ready && !redirect_valid) begin
                pc_log.push_back(inst_pc);
                data_log.push_back(inst_data);
            end
            if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
            if (w_req_valid && w_req_ready && w_req_log.size() < 3) w_req_log.push_back(w_req_addr);
            if (w_inst_valid && w_inst_ready && w_pc_log.size() < 3) begin
                w_pc_log.push_back(w_inst_pc);
                w_data_log.push_back(w_inst_data);
            end
        end else begin
            w_req_log.delete();
            w_pc_log.delete();
            w_data_log.delete();
        end
    end

    // holds reset for three edges, releases at posedge+1 (start of cycle c0)
    task automatic apply_reset(input int lat, input logic iready);
        @(posedge clk);
        #1;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = iready;
        mem_lat        = lat;
        repeat (3) @(posedge clk);
        #1;
        pc_log.delete();
        data_log.delete();
        req_log.delete();
        reset = 1'b1;
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (pc_log.size() < n && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("inst_log_fill", 32'(pc_log.size() >= n), 32'd1);
    endtask

    task automatic wait_req(input int n);
        int k = 0;
        while (req_log.size() < n && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("req_log_fill", 32'(req_log.size() >= n), 32'd1);
    endtask

    initial begin
        int idx;
        reset            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        imem_req_ready   = 1'b1;
        inst_ready       = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        w_req_ready      = 1'b1;
        w_inst_ready     = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req_valid",  32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data",  inst_data, 32'd0);
        chk("rst_inst_pc",    inst_pc, 32'd0);

        // sequential fetch, 1-cycle memory
        apply_reset(1, 1'b1);
        @(negedge clk);
        chk("seq_c0_req_valid", 32'(imem_req_valid), 32'd1);
        chk("seq_c0_req_addr",  imem_req_addr, 32'h0);
        chk("seq_c0_inst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        chk("seq_c1_req_addr",  imem_req_addr, 32'h4);
        chk("seq_c1_inst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        chk("seq_c2_inst_valid", 32'(inst_valid), 32'd1);
        chk("seq_c2_inst_pc",   inst_pc, 32'h0);
        chk("seq_c2_inst_data", inst_data, mem_word(32'h0));
        wait_log(4);
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc",   q_at(pc_log, i),   32'(4 * i));
            chk("seq_data", q_at(data_log, i), mem_word(32'(4 * i)));
        end

        // decode backpressure
        apply_reset(1, 1'b0);
        repeat (10) @(negedge clk);
        chk("bp_req_count", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("bp_req_addr", q_at(req_log, i), 32'(4 * i));
        chk("bp_req_valid",  32'(imem_req_valid), 32'd0);
        chk("bp_inst_valid", 32'(inst_valid), 32'd1);
        chk("bp_inst_pc",    inst_pc, 32'h0);
        chk("bp_inst_data",  inst_data, mem_word(32'h0));
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        wait_req(5);
        chk("bp_resume_addr", q_at(req_log, 4), 32'h10);
        wait_log(5);
        chk("bp_pc4", q_at(pc_log, 4), 32'h10);

        // redirect with two reads in flight, 3-cycle memory
        apply_reset(3, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        @(negedge clk);
        chk("rd_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("rd_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rd_req_addr",  imem_req_addr, 32'h40);
        wait_log(2);
        chk("rd_pc0",   q_at(pc_log, 0),   32'h40);
        chk("rd_data0", q_at(data_log, 0), mem_word(32'h40));
        chk("rd_pc1",   q_at(pc_log, 1),   32'h44);
        chk("rd_data1", q_at(data_log, 1), mem_word(32'h44));

        // misaligned redirect with a response and a pop in the same cycle
        apply_reset(1, 1'b1);
        wait_log(3);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        chk("al_pre_inst_valid", 32'(inst_valid), 32'd1);
        chk("al_pre_req_valid",  32'(imem_req_valid), 32'd0);
        idx = pc_log.size();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("al_req_addr",   imem_req_addr, 32'h100);
        chk("al_inst_valid", 32'(inst_valid), 32'd0);
        wait_log(idx + 1);
        chk("al_pc",   q_at(pc_log, idx),   32'h100);
        chk("al_data", q_at(data_log, idx), mem_word(32'h100));

        // reset mid-operation: 3 buffered, 1 outstanding
        apply_reset(3, 1'b0);
        repeat (7) @(negedge clk);
        chk("mr_pre_inst_valid", 32'(inst_valid), 32'd1);
        chk("mr_pre_inst_pc",    inst_pc, 32'h0);
        #1;
        reset = 1'b0;
        #1;
        chk("mr_req_valid",  32'(imem_req_valid), 32'd0);
        chk("mr_inst_valid", 32'(inst_valid), 32'd0);
        chk("mr_inst_data",  inst_data, 32'd0);
        chk("mr_inst_pc",    inst_pc, 32'd0);
        apply_reset(1, 1'b1);
        @(negedge clk);
        chk("mr_c0_req_addr",   imem_req_addr, 32'h0);
        chk("mr_c0_inst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        chk("mr_c1_inst_valid", 32'(inst_valid), 32'd0);
        wait_log(2);
        chk("mr_pc0", q_at(pc_log, 0), 32'h0);
        chk("mr_pc1", q_at(pc_log, 1), 32'h4);

        // wrap-around instance, running since the last reset release
        repeat (6) @(negedge clk);
        chk("wr_req0", q_at(w_req_log, 0), 32'hFFFF_FFF8);
        chk("wr_req1", q_at(w_req_log, 1), 32'hFFFF_FFFC);
        chk("wr_req2", q_at(w_req_log, 2), 32'h0000_0000);
        chk("wr_pc0",  q_at(w_pc_log, 0),  32'hFFFF_FFF8);
        chk("wr_pc1",  q_at(w_pc_log, 1),  32'hFFFF_FFFC);
        chk("wr_pc2",  q_at(w_pc_log, 2),  32'h0000_0000);
        chk("wr_data2", q_at(w_data_log, 2), mem_word(32'h0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
